sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Control and datapath wrapper that turns the dual-port synchronous RAM into a single-clock FIFO. RAM port 1 is the write side and RAM port 2 is the read side. The block owns the pointers, occupancy count, status flags and read-data hold register. The RAM instance is external and connects through the ram_* ports.

Parameters:
ADDR_WIDTH, 10, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, word width
AFULL_THRESH, DEPTH-2, afull_o asserts when count >= this
AEMPTY_THRESH, 2, aempty_o asserts when count <= this

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en_i  in  1  write request
wr_data_i  in  DATA_WIDTH  write word
rd_en_i  in  1  read request
rd_data_o  out  DATA_WIDTH  read word, held between reads
rd_valid_o  out  1  rd_data_o carries a newly popped word this cycle
full_o / empty_o  out  1  status flags
afull_o / aempty_o  out  1  threshold flags
count_o  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow_o / underflow_o  out  1  sticky error flags
err_clr_i  in  1  clears both sticky flags
ram_cs_o  out  1  RAM chip select
ram_wren1_o  out  1  port 1 write enable
ram_addr1_o  out  ADDR_WIDTH  write address
ram_wr_data1_o  out  DATA_WIDTH  write data
ram_wren2_o  out  1  port 2 write enable, constant 0
ram_addr2_o  out  ADDR_WIDTH  read address
ram_rd_data2_i  in  DATA_WIDTH  port 2 registered read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, aempty_o=1, full_o=0, afull_o=0, rd_valid_o=0, rd_data_o=0, overflow_o=0, underflow_o=0, ram_cs_o=0.
- ram_cs_o is registered and goes to 1 on the first edge after reset release, then stays 1. RAM contents are never cleared.
- Write accept: wr_fire = wr_en_i & ~full_o.
  - ram_wren1_o = wr_fire (combinational).
  - ram_addr1_o = wr_ptr; ram_wr_data1_o = wr_data_i.
  - wr_ptr increments on wr_fire and wraps DEPTH-1 -> 0.
- Read accept: rd_fire = rd_en_i & ~empty_o.
  - ram_addr2_o = rd_ptr. The RAM samples port 2 every cycle because cs=1 and wren2=0.
  - rd_ptr increments on rd_fire and wraps DEPTH-1 -> 0.
- Read latency: a pop accepted at edge N gives rd_valid_o=1 during the cycle after N, with rd_data_o = ram_rd_data2_i.
  - When rd_valid_o=0, rd_data_o holds the last popped word from an internal register.
- Count and flags: count += wr_fire - rd_fire; simultaneous accepts leave count unchanged.
  - full_o = (count==DEPTH); empty_o = (count==0).
  - afull_o and aempty_o follow the thresholds. All flags are registered from next-count, so they are valid the cycle after the causing edge.
- Write-to-read: a word written at edge M can be popped at edge M+1 at the earliest. Its data appears in the cycle after M+1, and the RAM returns the new value, never stale data.
- Full plus simultaneous rd/wr: the read is accepted and the write is rejected. Write acceptance looks only at the current full_o.
- Empty plus simultaneous rd/wr: the write is accepted and the read is rejected.
- Wrap-around: pointers are ADDR_WIDTH bits. Full and empty are decided by count_o, never by pointer comparison.
- Reset mid-operation: everything returns to reset values immediately. A pending rd_valid_o drops asynchronously.

Optional Feature:
SYNC_FIFO_ERR_FLAGS_EN
- Defined:
  - overflow_o sets on wr_en_i & full_o; underflow_o sets on rd_en_i & empty_o.
  - Both are sticky until err_clr_i=1 or reset.
  - If a set and a clear occur in the same cycle, set wins.
- Undefined: overflow_o and underflow_o are tied to 0, and err_clr_i is ignored. Ports remain present.

Test Plan:
- ADDR_WIDTH=2 (DEPTH 4): write 0xA1..0xA4 on 4 consecutive cycles -> count_o 1,2,3,4; full_o=1 after the 4th edge; afull_o=1 at count 2.
- From full, write 0xFF -> count stays 4, ram_wren1_o=0; overflow_o=1 with SYNC_FIFO_ERR_FLAGS_EN, 0 without.
- Pop 4 words -> rd_valid_o pulses with 0xA1,0xA2,0xA3,0xA4 one cycle after each accept; empty_o=1 after the last; rd_data_o holds 0xA4.
- Write 6 words, popping after each, so pointers wrap -> output sequence matches input in order, count_o never exceeds 1.
- Empty FIFO, rd_en_i+wr_en_i together with data 0x5C -> read rejected, count_o=1. Next cycle rd_en_i -> 0x5C with rd_valid_o.
- Count 2, assert rst_n=0 mid-burst -> all outputs return to reset values asynchronously; after release, empty_o=1 and count_o=0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around an external dual-port RAM.
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i,
  output logic                  ram_cs_o,
  output logic                  ram_wren1_o,
  output logic [ADDR_WIDTH-1:0] ram_addr1_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data1_o,
  output logic                  ram_wren2_o,
  output logic [ADDR_WIDTH-1:0] ram_addr2_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data2_i
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C =
    (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C =
    (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  afull_q, aempty_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic                  cs_q;
  logic                  wr_fire, rd_fire;

  assign wr_fire = wr_en_i & ~full_q;
  assign rd_fire = rd_en_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Capture the popped word during its valid cycle, since the RAM
  // output moves on as soon as rd_ptr advances.
  assign rd_hold_d = rd_valid_q ? ram_rd_data2_i : rd_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
      cs_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      afull_q    <= (count_d >= AF_C);
      aempty_q   <= (count_d <= AE_C);
      rd_valid_q <= rd_fire;
      rd_hold_q  <= rd_hold_d;
      cs_q       <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Set takes priority over a same-cycle clear.
  assign ovf_d = (wr_en_i & full_q) | (ovf_q & ~err_clr_i);
  assign udf_d = (rd_en_i & empty_q) | (udf_q & ~err_clr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

  assign rd_data_o      = rd_valid_q ? ram_rd_data2_i : rd_hold_q;
  assign rd_valid_o     = rd_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign afull_o        = afull_q;
  assign aempty_o       = aempty_q;
  assign count_o        = count_q;
  assign ram_cs_o       = cs_q;
  assign ram_wren1_o    = wr_fire;
  assign ram_addr1_o    = wr_ptr_q;
  assign ram_wr_data1_o = wr_data_i;
  assign ram_wren2_o    = 1'b0;
  assign ram_addr2_o    = rd_ptr_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized bench for sync_fifo_ctrl with a queue reference model
// and a behavioural dual-port RAM.
module tb_sync_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i, rd_en_i, err_clr_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o, full_o, empty_o;
  logic          afull_o, aempty_o;
  logic [AW:0]   count_o;
  logic          overflow_o, underflow_o;
  logic          ram_cs_o, ram_wren1_o, ram_wren2_o;
  logic [AW-1:0] ram_addr1_o, ram_addr2_o;
  logic [DW-1:0] ram_wr_data1_o, ram_rd_data2_i;

  sync_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .rd_en_i       (rd_en_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .afull_o       (afull_o),
    .aempty_o      (aempty_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .err_clr_i     (err_clr_i),
    .ram_cs_o      (ram_cs_o),
    .ram_wren1_o   (ram_wren1_o),
    .ram_addr1_o   (ram_addr1_o),
    .ram_wr_data1_o(ram_wr_data1_o),
    .ram_wren2_o   (ram_wren2_o),
    .ram_addr2_o   (ram_addr2_o),
    .ram_rd_data2_i(ram_rd_data2_i)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs_o) begin
      if (ram_wren1_o) mem[ram_addr1_o] <= ram_wr_data1_o;
      ram_rd_data2_i <= mem[ram_addr2_o];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_hold;
  bit            m_valid, m_ovf, m_udf;
  int            wr_tot, rd_tot;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hold  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    wr_tot  = 0;
    rd_tot  = 0;
  endtask

  task automatic check_reset();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_aempty", aempty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_afull", afull_o, 0);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_udf", underflow_o, 0);
    chk("rst_cs", ram_cs_o, 0);
    chk("rst_addr1", ram_addr1_o, 0);
    chk("rst_addr2", ram_addr2_o, 0);
  endtask

  task automatic check_outs();
    int n;
    n = q.size();
    chk("count", count_o, n);
    chk("full", full_o, n == DEPTH);
    chk("empty", empty_o, n == 0);
    chk("afull", afull_o, n >= DEPTH - 2);
    chk("aempty", aempty_o, n <= 2);
    chk("rd_valid", rd_valid_o, m_valid);
    chk("rd_data", rd_data_o, m_hold);
    chk("overflow", overflow_o, m_ovf);
    chk("underflow", underflow_o, m_udf);
    chk("cs", ram_cs_o, 1);
    chk("wren2", ram_wren2_o, 0);
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d,
                      input bit rd, input bit clr);
    bit wf, rf;
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    err_clr_i = clr;
    #3;
    wf = wr && (q.size() != DEPTH);
    rf = rd && (q.size() != 0);
    chk("wren1", ram_wren1_o, wf);
    chk("addr1", ram_addr1_o, wr_tot % DEPTH);
    chk("addr2", ram_addr2_o, rd_tot % DEPTH);
    chk("wdata1", ram_wr_data1_o, d);
    @(posedge clk);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    if (wr && q.size() == DEPTH) m_ovf = 1'b1;
    else if (clr)                m_ovf = 1'b0;
    if (rd && q.size() == 0)     m_udf = 1'b1;
    else if (clr)                m_udf = 1'b0;
`endif
    if (rf) begin
      m_hold = q.pop_front();
      rd_tot++;
    end
    if (wf) begin
      q.push_back(d);
      wr_tot++;
    end
    m_valid = rf;
    #1;
    check_outs();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cs_before_edge", ram_cs_o, 0);
    step(0, 8'h00, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en_i   = 1'b0;
    rd_en_i   = 1'b0;
    err_clr_i = 1'b0;
    wr_data_i = '0;
    model_reset();
    #12;
    check_reset();
    release_reset();

    for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h30 + 8'(i), 0, 0);
      step(0, 8'h00, 1, 0);
    end
    step(1, 8'h5C, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h33, 0, 0);
    wr_en_i = 1'b1;
    rd_en_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    release_reset();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 10);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
